// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: state encoding, source indices and
// tenure counter width.
package bus_arbiter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  localparam logic [1:0] SRC_CEO  = 2'd0;
  localparam logic [1:0] SRC_YOU  = 2'd1;
  localparam logic [1:0] SRC_FRED = 2'd2;
  localparam logic [1:0] SRC_JILL = 2'd3;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request starting at `start`,
// wrapping through all four positions; an excluded index is skipped entirely.
module rr_pick4
  import bus_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] start,
  input  logic       exclude_en,
  input  logic [1:0] exclude,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && req[cand] && !(exclude_en && (cand == exclude))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for four sources with bounded tenure; drives the
// downstream selector's sel/enable plus a one-hot grant, all registered.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       enable,
  output logic [3:0] grant
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       grant_q, grant_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic       rearb;

  // While owning, last_q equals the owner, so starting at last+1 leaves the
  // owner as the final candidate for both the idle pick and the handover.
  rr_pick4 u_pick (
    .req        (req),
    .start      (next_idx(last_q)),
    .exclude_en (1'b0),
    .exclude    (SRC_CEO),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign rearb = !req[sel_q] || (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_OWN;
          sel_d      = pick_idx;
          last_d     = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ST_OWN: begin
        if (rearb) begin
          hold_cnt_d = '0;
          if (pick_found) begin
            sel_d  = pick_idx;
            last_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
    grant_d = (state_d == ST_OWN) ? (4'b0001 << sel_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= SRC_CEO;
      last_q     <= SRC_JILL;
      hold_cnt_q <= '0;
      grant_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
    end
  end

  assign sel    = sel_q;
  assign enable = (state_q == ST_OWN);
  assign grant  = grant_q;

endmodule
